// File: rtl/aes_host_driver.sv
// aes_host_driver: host-side initiator for the AES engine byte interface.
// Latches a key/plaintext pair on start, streams them MSB byte first on
// eng_din/eng_cmd, issues GO, reassembles the 16 returned ciphertext bytes
// and reports them with a done pulse (or err_timeout if the engine stalls).
// Optional build macro AES_DRV_KEY_CACHE_EN: remember the last key loaded
// into the engine and skip the KEY burst when the next job reuses it.
module aes_host_driver #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [127:0] key_in,
  input  logic [127:0] plain_in,
  input  logic         start,
  output logic         busy,
  output logic [7:0]   eng_din,
  output logic [1:0]   eng_cmd,
  input  logic         eng_ready,
  input  logic [7:0]   eng_dout,
  input  logic         eng_data_ok,
  output logic [127:0] cipher_out,
  output logic         done,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_SEND_KEY,
    S_SEND_PT,
    S_SEND_GO,
    S_RECV,
    S_DONE,
    S_ABORT
  } state_e;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_KEY   = 2'b01;
  localparam logic [1:0] CMD_PLAIN = 2'b10;
  localparam logic [1:0] CMD_GO    = 2'b11;

  // Last waiting cycle before giving up: the counter holds the number of
  // cycles already spent waiting.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [127:0]           key_q, pt_q;
  logic [119:0]           shift_q, shift_d;
  logic                   load_ops;
  logic                   take_last;
  logic [1:0]             cmd_d, cmd_q;
  logic [7:0]             din_d, din_q;
  logic                   busy_q, done_q, err_q;
  logic [127:0]           cipher_q;
  logic                   key_hit;

`ifdef AES_DRV_KEY_CACHE_EN
  logic [127:0] last_key_q;
  logic         key_valid_q;
  logic         key_store;

  // The engine keeps its key, so a matching, still-valid key need not be resent.
  assign key_store = (state_q == S_SEND_KEY) && (cnt_q == 4'd15);
  assign key_hit   = key_valid_q && (key_q == last_key_q);

  // Cache validity: set once a full key burst went out, dropped on abort.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      key_valid_q <= 1'b0;
    end else if (state_q == S_ABORT) begin
      key_valid_q <= 1'b0;
    end else if (key_store) begin
      key_valid_q <= 1'b1;
    end
  end

  // Copy of the key last loaded into the engine (meaningful only while valid).
  always_ff @(posedge clk) begin
    if (key_store) begin
      last_key_q <= key_q;
    end
  end
`else
  assign key_hit = 1'b0;
`endif

  // Next-state, counter and receive-shift logic.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    load_ops  = 1'b0;
    take_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_ops = 1'b1;
          cnt_d    = 4'd0;
          tmo_d    = '0;
          state_d  = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (eng_ready) begin
          cnt_d   = 4'd0;
          state_d = key_hit ? S_SEND_PT : S_SEND_KEY;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      S_SEND_KEY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_SEND_PT;
        end
      end
      S_SEND_PT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_SEND_GO;
        end
      end
      S_SEND_GO: begin
        cnt_d   = 4'd0;
        tmo_d   = '0;
        state_d = S_RECV;
      end
      S_RECV: begin
        if (eng_data_ok) begin
          shift_d = {shift_q[111:0], eng_dout};
          cnt_d   = cnt_q + 4'd1;
          tmo_d   = '0;
          if (cnt_q == 4'd15) begin
            take_last = 1'b1;
            state_d   = S_DONE;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + TIMEOUT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Engine bus values for the state being entered, so the registered
  // outputs line up with the state register.
  always_comb begin
    cmd_d = CMD_NOP;
    din_d = 8'h00;
    case (state_d)
      S_SEND_KEY: begin
        cmd_d = CMD_KEY;
        din_d = key_q[{~cnt_d, 3'b000} +: 8];
      end
      S_SEND_PT: begin
        cmd_d = CMD_PLAIN;
        din_d = pt_q[{~cnt_d, 3'b000} +: 8];
      end
      S_SEND_GO: cmd_d = CMD_GO;
      default: begin
        cmd_d = CMD_NOP;
        din_d = 8'h00;
      end
    endcase
  end

  // Control state and all registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      tmo_q    <= '0;
      cmd_q    <= CMD_NOP;
      din_q    <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cipher_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      cmd_q   <= cmd_d;
      din_q   <= din_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ABORT);
      if (take_last) begin
        cipher_q <= {shift_q, eng_dout};
      end
    end
  end

  // Operand and receive datapath.
  // NOTE: these wide registers carry no reset; each is fully loaded before
  // it is ever observed, so resetting them would only add fan-out.
  always_ff @(posedge clk) begin
    if (load_ops) begin
      key_q <= key_in;
      pt_q  <= plain_in;
    end
    shift_q <= shift_d;
  end

  assign busy        = busy_q;
  assign eng_cmd     = cmd_q;
  assign eng_din     = din_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign cipher_out  = cipher_q;

endmodule
